// File: rtl/mole_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : mole_spawner
//  Description : Mole request responder for the whac-a-mole game FSM.
//                On each ready_for_mole pulse it picks a pseudo-random mole
//                from a free-running 16-bit Galois LFSR and drives it one-hot
//                on led_number. The same pulse raises timeout and starts a
//                per-level lifetime countdown. The countdown advances only
//                while timeout_start is high. spawn_count counts spawns
//                since reset.
//  Ports       : clk            - sole clock, rising edge
//                reset          - synchronous, active-high
//                ready_for_mole - request pulse: new mole, new lifetime
//                timeout_start  - enables the lifetime countdown
//                level_number   - level select (0 = hold latched level)
//                led_number     - one-hot active mole (registered)
//                timeout        - 1 while the lifetime remains (registered)
//                spawn_count    - spawns since reset, wraps mod 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_spawner #(
    parameter int          NUM_MOLES     = 18,
    parameter int unsigned LEVEL1_CYCLES = 50_000_000,
    parameter int unsigned LEVEL2_CYCLES = 25_000_000,
    parameter int unsigned LEVEL3_CYCLES = 12_500_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    input  logic [1:0]           level_number,
    output logic [NUM_MOLES-1:0] led_number,
    output logic                 timeout,
    output logic [15:0]          spawn_count
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] c_seed  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] c_taps  = 16'hB400;
    localparam logic [5:0]  c_num   = 6'(NUM_MOLES);
    localparam logic [31:0] c_load1 = 32'(LEVEL1_CYCLES - 1);
    localparam logic [31:0] c_load2 = 32'(LEVEL2_CYCLES - 1);
    localparam logic [31:0] c_load3 = 32'(LEVEL3_CYCLES - 1);

    logic [15:0]          r_lfsr;
    logic [1:0]           r_level;
    logic [31:0]          r_countdown;
    logic [5:0]           r_prev_idx;
    logic                 r_prev_valid;
    logic [NUM_MOLES-1:0] r_led;
    logic                 r_timeout;
    logic [15:0]          r_spawn_count;

    logic [15:0]          w_lfsr_next;
    logic [5:0]           w_raw;
    logic [5:0]           w_idx_mod;
    logic [5:0]           w_idx_inc;
    logic [5:0]           w_idx;
    logic [NUM_MOLES-1:0] w_onehot;
    logic [31:0]          w_load;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_taps : 16'h0000);

    // raw < 32 and NUM_MOLES >= 16, so one conditional subtract lands in range.
    assign w_raw     = {1'b0, r_lfsr[4:0]};
    assign w_idx_mod = (w_raw >= c_num) ? (w_raw - c_num) : w_raw;
    assign w_idx_inc = w_idx_mod + 6'd1;

    // Bump to the next mole (with wrap) so the same LED never lights twice in a row.
    always_comb begin
        w_idx = w_idx_mod;
        if (r_prev_valid && (w_idx_mod == r_prev_idx)) begin
            w_idx = (w_idx_inc == c_num) ? 6'd0 : w_idx_inc;
        end
    end

    assign w_onehot = {{(NUM_MOLES-1){1'b0}}, 1'b1} << w_idx;

    // The latched level is never 0, so the default arm serves level 3.
    always_comb begin
        case (r_level)
            2'd1:    w_load = c_load1;
            2'd2:    w_load = c_load2;
            default: w_load = c_load3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr        <= c_seed;
            r_level       <= 2'd1;
            r_countdown   <= 32'd0;
            r_prev_idx    <= 6'd0;
            r_prev_valid  <= 1'b0;
            r_led         <= '0;
            r_timeout     <= 1'b0;
            r_spawn_count <= 16'd0;
        end else begin
            r_lfsr <= w_lfsr_next;

            if (level_number != 2'd0) begin
                r_level <= level_number;
            end

            // A request outranks the countdown: reload, never decrement.
            if (ready_for_mole) begin
                r_led         <= w_onehot;
                r_prev_idx    <= w_idx;
                r_prev_valid  <= 1'b1;
                r_timeout     <= 1'b1;
                r_countdown   <= w_load;
                r_spawn_count <= r_spawn_count + 16'd1;
            end else if (timeout_start && r_timeout) begin
                if (r_countdown == 32'd0) begin
                    r_timeout <= 1'b0;
                end else begin
                    r_countdown <= r_countdown - 32'd1;
                end
            end
        end
    end

    assign led_number  = r_led;
    assign timeout     = r_timeout;
    assign spawn_count = r_spawn_count;

endmodule
`default_nettype wire

// File: tb/tb_mole_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_spawner
//  Description : Self-checking bench for mole_spawner (18 moles, level
//                lifetimes 4/3/2 cycles). Inputs change on the falling edge;
//                outputs are sampled on the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_spawner;

    localparam int          c_moles = 18;
    localparam logic [15:0] c_seed  = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        ready_for_mole;
    logic        timeout_start;
    logic [1:0]  level_number;
    logic [17:0] led_number;
    logic        timeout;
    logic [15:0] spawn_count;

    int checks   = 0;
    int failures = 0;

    // Reference state derived from the documented behaviour.
    logic [15:0] m_lfsr;
    logic        m_prev_valid;
    int          m_prev_idx;
    int          m_spawns;

    mole_spawner #(
        .NUM_MOLES     (c_moles),
        .LEVEL1_CYCLES (4),
        .LEVEL2_CYCLES (3),
        .LEVEL3_CYCLES (2),
        .LFSR_SEED     (c_seed)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ready_for_mole (ready_for_mole),
        .timeout_start  (timeout_start),
        .level_number   (level_number),
        .led_number     (led_number),
        .timeout        (timeout),
        .spawn_count    (spawn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) m_lfsr <= c_seed;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick(input logic [15:0] l, input logic pv, input int pidx);
        int idx;
        idx = int'(l[4:0]);
        if (idx >= c_moles) idx = idx - c_moles;
        if (pv && idx == pidx) idx = (idx + 1 == c_moles) ? 0 : idx + 1;
        return idx;
    endfunction

    // Drive one ready_for_mole cycle; return the mole the model expects.
    task automatic spawn(input logic ts, output logic [17:0] exp_led);
        int idx;
        idx            = pick(m_lfsr, m_prev_valid, m_prev_idx);
        ready_for_mole = 1'b1;
        timeout_start  = ts;
        tick();
        ready_for_mole = 1'b0;
        m_prev_valid   = 1'b1;
        m_prev_idx     = idx;
        m_spawns       = m_spawns + 1;
        exp_led        = 18'd1 << idx;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset        = 1'b0;
        m_prev_valid = 1'b0;
        m_prev_idx   = 0;
        m_spawns     = 0;
    endtask

    // Count consecutive cycles with timeout high, holding timeout_start high.
    task automatic count_high(output int n);
        n = 0;
        timeout_start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (timeout !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        logic [17:0] e;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (led_number !== 18'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", led_number, 18'h0); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (spawn_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", spawn_count); end
        do_reset(0);
        spawn(1'b0, e);
        checks++; if (led_number !== 18'h00002) begin failures++; $display("FAIL first_pick got=%h exp=%h", led_number, 18'h00002); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL first_timeout got=%b exp=1", timeout); end
        checks++; if (spawn_count !== 16'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", spawn_count); end
    endtask

    task automatic test_level(input logic [1:0] lvl, input int d);
        logic [17:0] e;
        int n;
        level_number = lvl;
        tick();
        level_number = 2'd0;
        tick();
        spawn(1'b0, e);
        checks++; if (led_number !== e) begin failures++; $display("FAIL level%0d_led got=%h exp=%h", lvl, led_number, e); end
        count_high(n);
        checks++; if (n != d) begin failures++; $display("FAIL level%0d_lifetime got=%0d exp=%0d", lvl, n, d); end
        repeat (3) tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL level%0d_stays_low got=%b exp=0", lvl, timeout); end
        checks++; if (led_number !== e) begin failures++; $display("FAIL level%0d_led_hold got=%h exp=%h", lvl, led_number, e); end
        timeout_start = 1'b0;
    endtask

    task automatic test_pause;
        logic [17:0] e;
        int n;
        level_number = 2'd1;
        tick();
        level_number = 2'd0;
        spawn(1'b0, e);
        n = 0;
        // Cycle k after the request: timeout_start low for k = 3..7.
        for (int k = 1; k <= 100; k++) begin
            if (timeout !== 1'b1) break;
            n++;
            timeout_start = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
            tick();
        end
        checks++; if (n != 9) begin failures++; $display("FAIL pause_lifetime got=%0d exp=9", n); end
        timeout_start = 1'b0;
    endtask

    task automatic test_priority;
        logic [17:0] e;
        logic [17:0] prev;
        int n;
        spawn(1'b0, e);
        prev = led_number;
        timeout_start = 1'b1;
        repeat (3) tick();  // countdown now 0, timeout still 1
        spawn(1'b1, e);
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL prio_timeout got=%b exp=1", timeout); end
        checks++; if (led_number !== e) begin failures++; $display("FAIL prio_led got=%h exp=%h", led_number, e); end
        checks++; if (led_number === prev) begin failures++; $display("FAIL prio_differs got=%h prev=%h", led_number, prev); end
        count_high(n);
        checks++; if (n != 4) begin failures++; $display("FAIL prio_reload got=%0d exp=4", n); end
        // Restart while the lifetime is still running.
        spawn(1'b1, e);
        tick();
        spawn(1'b1, e);
        checks++; if (led_number !== e) begin failures++; $display("FAIL restart_led got=%h exp=%h", led_number, e); end
        count_high(n);
        checks++; if (n != 4) begin failures++; $display("FAIL restart_lifetime got=%0d exp=4", n); end
        timeout_start = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [17:0] e;
        spawn(1'b0, e);
        timeout_start = 1'b1;
        tick();
        do_reset(1);
        checks++; if (led_number !== 18'h0) begin failures++; $display("FAIL midreset_led got=%h exp=0", led_number); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL midreset_timeout got=%b exp=0", timeout); end
        checks++; if (spawn_count !== 16'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", spawn_count); end
        timeout_start = 1'b0;
        spawn(1'b0, e);
        checks++; if (led_number !== 18'h00002) begin failures++; $display("FAIL midreset_repick got=%h exp=%h", led_number, 18'h00002); end
        checks++; if (spawn_count !== 16'd1) begin failures++; $display("FAIL midreset_count1 got=%0d exp=1", spawn_count); end
    endtask

    task automatic test_random;
        logic [17:0] e;
        logic [17:0] prev;
        logic [17:0] seen;
        do_reset(1);
        prev = '0;
        seen = '0;
        for (int s = 0; s < 2000; s++) begin
            spawn(1'($urandom_range(0, 1)), e);
            checks++; if (led_number !== e) begin failures++; $display("FAIL rand_led spawn=%0d got=%h exp=%h", s, led_number, e); end
            checks++; if (!$onehot(led_number)) begin failures++; $display("FAIL rand_onehot spawn=%0d got=%h", s, led_number); end
            checks++; if (led_number === prev) begin failures++; $display("FAIL rand_repeat spawn=%0d got=%h prev=%h", s, led_number, prev); end
            prev = led_number;
            seen = seen | led_number;
            repeat ($urandom_range(0, 3)) begin
                timeout_start = 1'($urandom_range(0, 1));
                tick();
            end
        end
        checks++; if (seen !== 18'h3FFFF) begin failures++; $display("FAIL rand_coverage got=%h exp=%h", seen, 18'h3FFFF); end
        checks++; if (spawn_count !== 16'd2000) begin failures++; $display("FAIL rand_count got=%0d exp=2000", spawn_count); end
        timeout_start = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        ready_for_mole = 1'b0;
        timeout_start  = 1'b0;
        level_number   = 2'd0;
        m_prev_valid   = 1'b0;
        m_prev_idx     = 0;
        m_spawns       = 0;
        @(negedge clk);
        test_reset();
        test_level(2'd2, 3);
        test_level(2'd1, 4);
        test_level(2'd3, 2);
        test_pause();
        test_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_spawner.md
# mole_spawner

Responder side of the whac-a-mole game FSM's mole request interface. On each one-cycle `ready_for_mole` request it picks a pseudo-random mole and drives it as a one-hot `led_number`. It also raises `timeout` and runs a per-level countdown that is gated by `timeout_start`. The block sits next to the game FSM, clocked by the same `clk`, and replaces any external random/timer source.

## Interface
- `NUM_MOLES`, 18: number of moles/LEDs; legal range 16–32.
- `LEVEL1_CYCLES`, 50_000_000: mole lifetime in `timeout_start`-high cycles at level 1; must be ≥1.
- `LEVEL2_CYCLES`, 25_000_000: lifetime at level 2; must be ≥1.
- `LEVEL3_CYCLES`, 12_500_000: lifetime at level 3; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready_for_mole`  in  1  request pulse from the game FSM: choose a new mole and start its lifetime.
- `timeout_start`  in  1  high while the FSM waits for a hit; enables the countdown.
- `level_number`  in  2  level select from the keys; 0 means no level key pressed.
- `led_number`  out  NUM_MOLES  one-hot active mole (all zero only after reset).
- `timeout`  out  1  high while the mole lifetime remains; low means expired (the FSM scores a miss on low).
- `spawn_count`  out  16  number of moles spawned since reset; wraps modulo 2^16.

## Operation
- **Reset values:**
  - `led_number`=0, `timeout`=0, `spawn_count`=0.
  - Countdown=0, LFSR=`LFSR_SEED`, latched level=1, `prev_valid`=0.
- **LFSR:** 16-bit Galois, advances every cycle including idle.
  - Update: lfsr ← {0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
  - It never reaches 0.
- **Level latch:** each cycle with `level_number`≠0, the latched level ← `level_number`. A value of 0 holds the previous latched level.
- **Mole pick** uses the LFSR value present in the `ready_for_mole` cycle:
  - raw = lfsr[4:0]; idx = raw ≥ NUM_MOLES ? raw − NUM_MOLES : raw.
  - One conditional subtract suffices because NUM_MOLES ≥ 16.
  - If `prev_valid` and idx == prev_idx, then idx ← (idx+1 == NUM_MOLES) ? 0 : idx+1. Consecutive moles always differ.
- **On a `ready_for_mole` cycle:**
  - `led_number` ← 1<<idx; prev_idx ← idx; `prev_valid` ← 1.
  - `timeout` ← 1; countdown ← D−1, where D is selected by the latched level (1→LEVEL1, 2→LEVEL2, 3→LEVEL3).
  - `spawn_count` ← `spawn_count`+1.
- **Countdown:** on a cycle with `ready_for_mole`=0, `timeout_start`=1 and `timeout`=1:
  - if countdown==0, then `timeout` ← 0;
  - else countdown ← countdown−1.
- **Pause:** `timeout_start`=0 holds the countdown and `timeout`.
- **After expiry:** `timeout` stays 0 and `led_number` holds until the next `ready_for_mole`.
- **Simultaneous events:**
  - `ready_for_mole` takes priority over `timeout_start`: reload, no decrement.
  - `reset` takes priority over everything.
- **Request during an active lifetime:** `ready_for_mole` while `timeout`=1 restarts the lifetime with a new mole.
- **Reset mid-lifetime:** all outputs go to their reset values on the next edge. The next spawn does no repeat check.

## Timing
- **Latency:** `ready_for_mole` high in cycle T gives a new `led_number` and `timeout`=1 from cycle T+1. Both are valid in the FSM's first wait cycle.
- **Lifetime:** with `timeout_start` high continuously from T+1, `timeout` is 1 for cycles T+1..T+D and 0 from T+D+1.
- **Pauses:** each cycle of `timeout_start`=0 inside the window extends the lifetime by one cycle.
- **Registration:** all outputs are registered; no combinational path from any input to any output.
- **Countdown width:** 32 bits. Parameters must fit in it.

## Test plan
1. **Reset and first pick.** Hold `reset` 2 cycles, then pulse `ready_for_mole` in the first cycle after reset (lfsr=ACE1, raw=1).
   - Next cycle: `led_number`=18'h00002, `timeout`=1, `spawn_count`=1.
2. **Lifetime per level.** Use LEVEL1/2/3_CYCLES=4/3/2. Set `level_number`=2, then 0; pulse `ready_for_mole`, then hold `timeout_start`.
   - `timeout` is high for exactly 3 cycles, then low, and stays low with `led_number` held.
   - Repeat with levels 1 and 3: high for 4 and 2 cycles.
3. **Pause.** Level 1 (D=4). Deassert `timeout_start` for 5 cycles after the 2nd countdown cycle.
   - `timeout` is high for 9 cycles total; countdown frozen during the gap.
4. **Priority and restart.**
   - `ready_for_mole` and `timeout_start` both high at countdown==0: `timeout` stays 1, the countdown reloads, and the mole differs from the previous one.
   - `ready_for_mole` mid-lifetime also restarts the lifetime.
5. **Reset mid-lifetime.** Assert `reset` while `timeout`=1.
   - Next cycle: `led_number`=0, `timeout`=0, `spawn_count`=0. A following spawn reproduces scenario 1's value.
6. **Randomised spawn properties.** 2000 spawns with random gaps.
   - Every `led_number` is one-hot with index <18.
   - No two consecutive moles are equal.
   - All 18 indices appear.
   - `spawn_count` equals 2000 mod 2^16.
